irq_ctrl: RTL and testbench

- Interrupt source for the core. It collects NUM_SRC external interrupt lines and synchronises them into the clock domain.
- Each rising edge is latched as a pending bit; masked, prioritised requests drive the single interrupt level the register file exposes when x4 is read.
- Software acknowledges through a handshake. The controller then releases the line and presents the next request.

---
 rtl/irq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_irq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl - edge-triggered interrupt controller for the core.
//
// Collects NUM_SRC asynchronous interrupt lines, synchronises them into the
// clk_i domain, latches each rising edge as a pending bit, applies a software
// mask and presents the lowest-index masked pending source as a single
// registered interrupt level. Software acknowledges the presented source with
// ack_i; the controller then drops the line for one cycle (GAP) before it
// presents the next request, so a polling reader always sees a deassertion.
//
// Handshake: interrupt_o=1 acts as "valid" for irq_id_o. An ack is accepted
// only on a rising clk_i edge where interrupt_o=1 (ASSERT state) and ack_i=1.
// That edge clears pending[irq_id_o]. ack_i at any other time is ignored.
//
// Ports:
//   clk_i        core clock, all state on the rising edge
//   rst_i        asynchronous active-high reset
//   src_i        raw asynchronous interrupt lines (active-high, edge-triggered)
//   mask_we_i    write enable for the mask register
//   mask_wd_i    new mask value, bit=1 enables the source
//   ack_i        acknowledge of the currently presented interrupt
//   interrupt_o  registered interrupt level
//   irq_id_o     index of the presented source, valid while interrupt_o=1
//   pending_o    raw (unmasked) pending register
//   mask_o       current mask register
//   dbg_state_o  FSM state (0=IDLE, 1=ASSERT, 2=GAP) for checkers/debug
// ---------------------------------------------------------------------------
module irq_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ID_WIDTH    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_SRC-1:0]  src_i,
    input  logic                mask_we_i,
    input  logic [NUM_SRC-1:0]  mask_wd_i,
    input  logic                ack_i,
    output logic                interrupt_o,
    output logic [ID_WIDTH-1:0] irq_id_o,
    output logic [NUM_SRC-1:0]  pending_o,
    output logic [NUM_SRC-1:0]  mask_o,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_GAP    = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NUM_SRC-1:0]  sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0]  hist_q;
    logic [NUM_SRC-1:0]  pending_q;
    logic [NUM_SRC-1:0]  pending_d;
    logic [NUM_SRC-1:0]  mask_q;
    logic [NUM_SRC-1:0]  mask_d;
    state_e              state_q;
    logic                interrupt_q;
    logic [ID_WIDTH-1:0] irq_id_q;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [NUM_SRC-1:0]  sync_last;
    logic [NUM_SRC-1:0]  rise;
    logic [NUM_SRC-1:0]  clr;
    logic [NUM_SRC-1:0]  req;
    logic [ID_WIDTH-1:0] win_id;
    logic                ack_accept;

    assign sync_last  = sync_q[SYNC_STAGES-1];
    // One event per 0->1 transition of the synchronised line.
    assign rise       = sync_last & ~hist_q;
    assign ack_accept = (state_q == S_ASSERT) && ack_i;
    assign req        = pending_q & mask_q;

    // Clear only the bit of the source currently being presented.
    always_comb begin
        clr = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            clr[n] = ack_accept && (irq_id_q == ID_WIDTH'(n));
        end
    end

    // A new edge on the same cycle as its own ack wins: the bit stays pending.
    always_comb begin
        pending_d = rise | (pending_q & ~clr);
    end

    always_comb begin
        mask_d = mask_q;
        if (mask_we_i) begin
            mask_d = mask_wd_i;
        end
    end

    // Fixed priority, lowest index wins: scan downwards so the last hit is
    // the lowest set bit.
    always_comb begin
        win_id = '0;
        for (int n = NUM_SRC - 1; n >= 0; n--) begin
            if (req[n]) begin
                win_id = ID_WIDTH'(n);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Synchroniser, edge history, pending and mask registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            sync_q[0] <= src_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q    <= sync_last;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // -----------------------------------------------------------------------
    // Presentation FSM with registered outputs.
    // irq_id_q is only loaded on IDLE->ASSERT, so it stays stable through
    // ASSERT regardless of mask or priority changes and keeps its last value
    // afterwards.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            interrupt_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req != '0) begin
                        state_q     <= S_ASSERT;
                        interrupt_q <= 1'b1;
                        irq_id_q    <= win_id;
                    end
                end
                S_ASSERT: begin
                    if (ack_i) begin
                        state_q     <= S_GAP;
                        interrupt_q <= 1'b0;
                    end
                end
                S_GAP: begin
                    // Forced one-cycle low so software polling sees a drop.
                    state_q     <= S_IDLE;
                    interrupt_q <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    interrupt_q <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign interrupt_o = interrupt_q;
    assign irq_id_o    = irq_id_q;
    assign pending_o   = pending_q;
    assign mask_o      = mask_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl (NUM_SRC=4, SYNC_STAGES=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_irq_ctrl;

  localparam int NUM_SRC = 4;
  localparam int ID_W    = 2;

  logic               clk;
  logic               rst;
  logic [NUM_SRC-1:0] src;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wd;
  logic               ack;
  logic               interrupt;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [1:0]         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ID_W-1:0] exp_q[$];

  irq_ctrl #(
    .NUM_SRC(NUM_SRC),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .src_i      (src),
    .mask_we_i  (mask_we),
    .mask_wd_i  (mask_wd),
    .ack_i      (ack),
    .interrupt_o(interrupt),
    .irq_id_o   (irq_id),
    .pending_o  (pending),
    .mask_o     (mask),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare the presented id against the oldest expected id.
  task automatic sb_pop_check(input string tag);
    logic [ID_W-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'(irq_id), 32'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_mask(input logic [NUM_SRC-1:0] m);
    mask_we = 1'b1;
    mask_wd = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Bounded wait for interrupt_o, then scoreboard compare of irq_id_o.
  task automatic wait_irq(input string tag);
    int cnt;
    cnt = 0;
    while (!interrupt && cnt < 20) begin
      tick();
      cnt++;
    end
    if (!interrupt) begin
      check_eq({tag, "_timeout"}, 32'(interrupt), 32'd1);
      void'(exp_q.pop_front());
    end else begin
      sb_pop_check(tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi_cnt;
    int n;
    rst     = 1'b1;
    src     = '0;
    mask_we = 1'b0;
    mask_wd = '0;
    ack     = 1'b0;
    tick();
    tick();

    // Reset values
    check_eq("rst_interrupt", 32'(interrupt), 32'd0);
    check_eq("rst_id", 32'(irq_id), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_mask", 32'(mask), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    // Basic latency on src[2]
    write_mask(4'b1111);
    check_eq("mask_write", 32'(mask), 32'hF);
    src[2] = 1'b1;
    exp_q.push_back(2'd2);
    tick();
    check_eq("lat_e0_pending", 32'(pending), 32'd0);
    tick();
    check_eq("lat_e1_pending", 32'(pending), 32'd0);
    tick();
    check_eq("lat_e2_pending", 32'(pending), 32'b0100);
    check_eq("lat_e2_irq", 32'(interrupt), 32'd0);
    tick();
    check_eq("lat_e3_irq", 32'(interrupt), 32'd1);
    sb_pop_check("lat_e3_id");
    ack_pulse();
    check_eq("lat_ack_irq", 32'(interrupt), 32'd0);
    check_eq("lat_ack_pending", 32'(pending), 32'd0);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (interrupt) hi_cnt++;
    end
    check_eq("hold_no_retrigger", 32'(hi_cnt), 32'd0);
    src = '0;
    repeat (4) tick();

    // Priority: src[3] and src[1] together -> 1 then 3
    src = 4'b1010;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    wait_irq("prio_first");
    ack_pulse();
    check_eq("prio_gap_low", 32'(interrupt), 32'd0);
    tick();
    check_eq("prio_idle_low", 32'(interrupt), 32'd0);
    tick();
    check_eq("prio_second_irq", 32'(interrupt), 32'd1);
    sb_pop_check("prio_second_id");
    ack_pulse();
    check_eq("prio_pending_end", 32'(pending), 32'd0);
    src = '0;
    repeat (4) tick();
    check_eq("prio_idle_end", 32'(interrupt), 32'd0);

    // Mask: masked pending is held, presented once unmasked
    write_mask(4'b0000);
    src[0] = 1'b1;
    tick();
    tick();
    src[0] = 1'b0;
    repeat (4) tick();
    check_eq("mask_pending", 32'(pending), 32'b0001);
    check_eq("mask_irq_low", 32'(interrupt), 32'd0);
    exp_q.push_back(2'd0);
    write_mask(4'b0001);
    check_eq("mask_w_edge_low", 32'(interrupt), 32'd0);
    tick();
    check_eq("mask_w_next_irq", 32'(interrupt), 32'd1);
    sb_pop_check("mask_id");
    ack_pulse();
    check_eq("mask_pending_clr", 32'(pending), 32'd0);
    repeat (3) tick();

    // Set-wins: new rise on src[1] in the cycle its ack is accepted
    write_mask(4'b1111);
    src[1] = 1'b1;
    exp_q.push_back(2'd1);
    wait_irq("setwin_first");
    src[1] = 1'b0;
    repeat (3) tick();
    check_eq("setwin_still_asserted", 32'(interrupt), 32'd1);
    src[1] = 1'b1;
    tick();
    tick();
    exp_q.push_back(2'd1);
    ack_pulse();
    check_eq("setwin_pending", 32'(pending[1]), 32'd1);
    check_eq("setwin_gap_low", 32'(interrupt), 32'd0);
    tick();
    check_eq("setwin_idle_low", 32'(interrupt), 32'd0);
    tick();
    check_eq("setwin_re_irq", 32'(interrupt), 32'd1);
    sb_pop_check("setwin_re_id");
    src[1] = 1'b0;
    ack_pulse();
    repeat (4) tick();
    check_eq("setwin_pending_end", 32'(pending), 32'd0);

    // Stray ack in IDLE
    ack_pulse();
    tick();
    check_eq("stray_irq", 32'(interrupt), 32'd0);
    check_eq("stray_pending", 32'(pending), 32'd0);
    check_eq("stray_state", 32'(dbg_state), 32'd0);
    check_eq("stray_id_kept", 32'(irq_id), 32'd1);
    check_eq("stray_mask", 32'(mask), 32'hF);

    // Clearing mask during ASSERT keeps the line up until ack
    src[2] = 1'b1;
    exp_q.push_back(2'd2);
    wait_irq("mclr_first");
    write_mask(4'b0000);
    repeat (3) tick();
    check_eq("mclr_irq_held", 32'(interrupt), 32'd1);
    check_eq("mclr_id_held", 32'(irq_id), 32'd2);
    ack_pulse();
    check_eq("mclr_ack_low", 32'(interrupt), 32'd0);
    src = '0;
    repeat (4) tick();
    check_eq("mclr_stays_low", 32'(interrupt), 32'd0);

    // Async reset mid-ASSERT with pending=0101
    write_mask(4'b1111);
    src = 4'b0101;
    exp_q.push_back(2'd0);
    wait_irq("arst_first");
    check_eq("arst_pending_before", 32'(pending), 32'b0101);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_irq", 32'(interrupt), 32'd0);
    check_eq("arst_pending", 32'(pending), 32'd0);
    check_eq("arst_mask", 32'(mask), 32'd0);
    tick();
    src = '0;
    rst = 1'b0;
    tick();

    // Random single-source events
    write_mask(4'b1111);
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, NUM_SRC - 1);
      src[n] = 1'b1;
      exp_q.push_back(ID_W'(n));
      wait_irq("rand_id");
      repeat ($urandom_range(0, 3)) tick();
      ack_pulse();
      src = '0;
      repeat (4) tick();
    end
    check_eq("rand_pending_end", 32'(pending), 32'd0);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
